census_bit_serializer: RTL and testbench

//  Upstream feeder of the serial-in/parallel-out census shift register. Captures a centre

---
 rtl/census_pkg.sv | 16 +
 rtl/census_bit_serializer_if.sv | 24 ++
 rtl/census_compare.sv | 29 ++
 rtl/census_bit_serializer.sv | 108 ++++++++++
 tb/tb_census_bit_serializer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/census_pkg.sv
// Shared definitions for the census bit serializer: FSM state encoding and counter sizing.
package census_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold a down-counter that starts at width and stops at zero
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/census_bit_serializer_if.sv
// Pixel stream and shift-register feed bundle of the census bit serializer.
interface census_bit_serializer_if #(
    parameter int unsigned PIX_W = 8
);
    logic             i_START;
    logic [PIX_W-1:0] i_CENTER;
    logic [PIX_W-1:0] i_PIX;
    logic             i_PIX_VALID;
    logic             o_PIX_READY;
    logic             o_SR_SI;
    logic             o_SR_EN;
    logic             o_BUSY;
    logic             o_DONE;

    modport master (
        output i_START, i_CENTER, i_PIX, i_PIX_VALID,
        input  o_PIX_READY, o_SR_SI, o_SR_EN, o_BUSY, o_DONE
    );

    modport slave (
        input  i_START, i_CENTER, i_PIX, i_PIX_VALID,
        output o_PIX_READY, o_SR_SI, o_SR_EN, o_BUSY, o_DONE
    );
endinterface

// File: rtl/census_compare.sv
// Combinational pixel-vs-centre census compare.
// CENSUS_TOL_EN: when defined, a pixel must be more than TOL levels darker than the
// centre to produce a 1 (noise dead-band); otherwise a plain unsigned less-than.
module census_compare
    import census_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned TOL   = 2
) (
    input  logic [PIX_W-1:0] pix,
    input  logic [PIX_W-1:0] center,
    output logic             bit_c
);

    localparam int unsigned SUM_W = PIX_W + 1;

    // TOL is a PIX_W-bit quantity
    if (TOL >= (1 << PIX_W)) begin : g_tol_range
        $error("census_compare: TOL does not fit in PIX_W bits");
    end

`ifdef CENSUS_TOL_EN
    // Sum kept one bit wider so pix + TOL never overflows
    assign bit_c = (SUM_W'(pix) + SUM_W'(TOL)) < SUM_W'(center);
`else
    assign bit_c = pix < center;
`endif

endmodule

// File: rtl/census_bit_serializer.sv
// Census bit serializer: captures a centre pixel, accepts WIDTH neighbour pixels over a
// valid/ready stream and emits one census bit per accepted pixel to a downstream
// serial-in shift register, then pulses o_DONE when the word is complete there.
// Optional feature macro: CENSUS_TOL_EN (tolerance dead-band in the compare).
module census_bit_serializer
    import census_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned TOL   = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    census_bit_serializer_if.slave   bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    if (WIDTH < 2) begin : g_width_range
        $error("census_bit_serializer: WIDTH must be at least 2");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [PIX_W-1:0] center;
    logic             sr_si;
    logic             sr_en;
    logic             ready_c;
    logic             busy_c;
    logic             done_c;
    logic             accept_c;
    logic             bit_c;

    census_compare #(
        .PIX_W (PIX_W),
        .TOL   (TOL)
    ) u_compare (
        .pix    (bus.i_PIX),
        .center (center),
        .bit_c  (bit_c)
    );

    // Counter guard keeps count from wrapping even if the FSM were ever out of step
    assign accept_c = bus.i_PIX_VALID & ready_c & (count != '0);

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one window per START, fixed FLUSH/DONE tail
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_START) state_nxt = SHIFT;
            SHIFT:   if (accept_c && (count == CNT_W'(1))) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        ready_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE:    ;
            SHIFT:   begin ready_c = 1'b1; busy_c = 1'b1; end
            FLUSH:   busy_c = 1'b1;
            DONE:    begin busy_c = 1'b1; done_c = 1'b1; end
            default: ;
        endcase
    end

    // Centre capture, remaining-pixel count and registered shift-register feed
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            count  <= '0;
            center <= '0;
            sr_si  <= 1'b0;
            sr_en  <= 1'b0;
        end else begin
            sr_en <= accept_c;
            if ((state == IDLE) && bus.i_START) begin
                center <= bus.i_CENTER;
                count  <= CNT_W'(WIDTH);
            end
            if (accept_c) begin
                count <= count - CNT_W'(1);
                sr_si <= bit_c;
            end
        end
    end

    assign bus.o_PIX_READY = ready_c;
    assign bus.o_SR_SI     = sr_si;
    assign bus.o_SR_EN     = sr_en;
    assign bus.o_BUSY      = busy_c;
    assign bus.o_DONE      = done_c;

endmodule

// File: tb/tb_census_bit_serializer.sv
// Self-checking bench for census_bit_serializer: directed windows plus randomized
// windows, scored against a pixel-list model and a downstream shift-register model.
module tb_census_bit_serializer;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned TOL   = 2;
`ifdef CENSUS_TOL_EN
    localparam int TOL_EFF = TOL;
`else
    localparam int TOL_EFF = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    census_bit_serializer_if #(.PIX_W(PIX_W)) bus_if ();

    census_bit_serializer #(
        .WIDTH (WIDTH),
        .PIX_W (PIX_W),
        .TOL   (TOL)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int              px [WIDTH];
    logic [WIDTH-1:0] sr_model = '0;
    int              en_cnt   = 0;
    int              done_cnt = 0;
    int              done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream shift register (SI enters at the MSB) and DONE observer
    always @(negedge clk) begin
        if (rst) begin
            sr_model = '0;
            en_cnt   = 0;
        end else begin
            if (bus_if.o_SR_EN === 1'b1) begin
                sr_model = {bus_if.o_SR_SI, sr_model[WIDTH-1:1]};
                en_cnt++;
            end
            if (bus_if.o_DONE === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Census word predicted from the pixel list: bit i set when pixel i is darker than centre
    function automatic logic [WIDTH-1:0] exp_word(input int c);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) w[i] = ((px[i] + TOL_EFF) < c);
        return w;
    endfunction

    // mode 0: valid always high, 1: valid toggling 1,0, 2: random valid
    task automatic run_window(input int c, input int mode, input bit inject, input bit check_after);
        int idx = 0, guard = 0, phase = 0, last_acc = -1, d0, g;
        bit v, prev_acc = 1'b0;
        logic [WIDTH-1:0] exp;
        d0 = done_cnt;
        exp = exp_word(c);
        @(posedge clk); #1;
        en_cnt = 0;
        bus_if.i_START = 1'b1; bus_if.i_CENTER = PIX_W'(c); bus_if.i_PIX_VALID = 1'b0;
        @(posedge clk); #1;
        bus_if.i_START = 1'b0; bus_if.i_CENTER = PIX_W'($urandom);
        while (idx < WIDTH && guard < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : 1'($urandom % 2);
            bus_if.i_PIX_VALID = v;
            bus_if.i_PIX = v ? PIX_W'(px[idx]) : PIX_W'($urandom);
            if (inject && phase == 3) begin
                bus_if.i_START = 1'b1; bus_if.i_CENTER = '0;
            end else begin
                bus_if.i_START = 1'b0;
            end
            @(negedge clk);
            total++;
            if (bus_if.o_PIX_READY !== 1'b1 || bus_if.o_BUSY !== 1'b1) begin
                bad++; $display("FAIL shift_ready: ready=%b busy=%b required 1/1 at pixel %0d", bus_if.o_PIX_READY, bus_if.o_BUSY, idx);
            end
            total++;
            if (bus_if.o_SR_EN !== prev_acc) begin
                bad++; $display("FAIL sr_en_timing: sr_en=%b required %b at pixel %0d", bus_if.o_SR_EN, prev_acc, idx);
            end
            prev_acc = v;
            if (v) begin idx++; last_acc = cyc; end
            @(posedge clk); #1;
            phase++; guard++;
        end
        bus_if.i_PIX_VALID = 1'b0; bus_if.i_START = 1'b0;
        total++;
        if (idx != WIDTH) begin
            bad++; $display("FAIL feed_timeout: accepted %0d pixels required %0d", idx, WIDTH);
        end
        g = 0;
        while (done_cnt == d0 && g < 20) begin
            @(negedge clk); #1;
            g++;
        end
        total++;
        if (done_cnt != d0 + 1) begin
            bad++; $display("FAIL done_timeout: done pulses %0d required %0d", done_cnt - d0, 1);
        end else begin
            total++;
            if (done_cyc - last_acc != 2) begin
                bad++; $display("FAIL done_latency: %0d cycles required 2", done_cyc - last_acc);
            end
            total++;
            if (sr_model !== exp) begin
                bad++; $display("FAIL census_word: got %b required %b (centre %0d)", sr_model, exp, c);
            end
            total++;
            if (en_cnt != WIDTH || bus_if.o_PIX_READY !== 1'b0) begin
                bad++; $display("FAIL done_state: en_count=%0d ready=%b required %0d/0", en_cnt, bus_if.o_PIX_READY, WIDTH);
            end
        end
        if (check_after) begin
            repeat (5) @(negedge clk);
            #1;
            total++;
            if (done_cnt != d0 + 1 || bus_if.o_BUSY !== 1'b0 || en_cnt != WIDTH) begin
                bad++; $display("FAIL after_window: done pulses %0d busy=%b en_count=%0d required 1/0/%0d", done_cnt - d0, bus_if.o_BUSY, en_cnt, WIDTH);
            end
        end
    endtask

    task automatic set_test1_pixels();
        int t1 [WIDTH] = '{50, 150, 100, 99, 101, 0, 255, 100, 20, 200};
        for (int i = 0; i < WIDTH; i++) px[i] = t1[i];
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus_if.o_PIX_READY, bus_if.o_SR_SI, bus_if.o_SR_EN, bus_if.o_BUSY, bus_if.o_DONE} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs: got %b required 00000",
                {bus_if.o_PIX_READY, bus_if.o_SR_SI, bus_if.o_SR_EN, bus_if.o_BUSY, bus_if.o_DONE});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] lit = 10'b01_0010_1001;
        set_test1_pixels();
        run_window(100, 0, 1'b0, 1'b1);
        total++;
        if (sr_model !== lit) begin
            bad++; $display("FAIL basic_word: got %b required %b", sr_model, lit);
        end
    endtask

    task automatic test_bubbles();
        set_test1_pixels();
        run_window(100, 1, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        set_test1_pixels();
        run_window(100, 0, 1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        int d0 = done_cnt;
        int n = 0, guard = 0;
        for (int i = 0; i < WIDTH; i++) px[i] = 10;
        @(posedge clk); #1;
        bus_if.i_START = 1'b1; bus_if.i_CENTER = 8'd100;
        @(posedge clk); #1;
        bus_if.i_START = 1'b0;
        bus_if.i_PIX_VALID = 1'b1; bus_if.i_PIX = 8'd10;
        while (n < 5 && guard < 50) begin
            @(negedge clk);
            if (bus_if.o_PIX_READY === 1'b1) n++;
            @(posedge clk); #1;
            guard++;
        end
        bus_if.i_PIX_VALID = 1'b0;
        total++;
        if (bus_if.o_SR_EN !== 1'b1 || bus_if.o_SR_SI !== 1'b1) begin
            bad++; $display("FAIL pre_reset_feed: sr_en=%b sr_si=%b required 1/1", bus_if.o_SR_EN, bus_if.o_SR_SI);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus_if.o_PIX_READY, bus_if.o_SR_SI, bus_if.o_SR_EN, bus_if.o_BUSY, bus_if.o_DONE} !== 5'b0) begin
            bad++; $display("FAIL mid_reset_outputs: got %b required 00000",
                {bus_if.o_PIX_READY, bus_if.o_SR_SI, bus_if.o_SR_EN, bus_if.o_BUSY, bus_if.o_DONE});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (done_cnt != d0 || bus_if.o_BUSY !== 1'b0) begin
            bad++; $display("FAIL mid_reset_no_done: done pulses %0d busy=%b required 0/0", done_cnt - d0, bus_if.o_BUSY);
        end
        set_test1_pixels();
        run_window(100, 0, 1'b0, 1'b1);
    endtask

    task automatic test_tolerance();
        logic [2:0] exp3;
`ifdef CENSUS_TOL_EN
        exp3 = 3'b001;
`else
        exp3 = 3'b111;
`endif
        px[0] = 97; px[1] = 98; px[2] = 99;
        for (int i = 3; i < WIDTH; i++) px[i] = int'($urandom_range(0, 255));
        run_window(100, 0, 1'b0, 1'b1);
        total++;
        if (sr_model[2:0] !== exp3) begin
            bad++; $display("FAIL tolerance_bits: got %b required %b", sr_model[2:0], exp3);
        end
    endtask

    task automatic test_random();
        int c;
        for (int w = 0; w < 8; w++) begin
            case (w)
                0:       c = 0;
                1:       c = 255;
                default: c = int'($urandom_range(0, 255));
            endcase
            for (int i = 0; i < WIDTH; i++) begin
                case ($urandom % 4)
                    0:       px[i] = c;
                    1:       px[i] = (c + int'($urandom_range(0, 4)) - 2) & 255;
                    default: px[i] = int'($urandom_range(0, 255));
                endcase
            end
            run_window(c, 2, 1'($urandom % 2), w[0]);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        set_test1_pixels();
        run_window(100, 0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) px[i] = int'($urandom_range(0, 255));
        run_window(int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) px[i] = int'($urandom_range(0, 255));
        run_window(int'($urandom_range(0, 255)), 2, 1'b0, 1'b1);
        total++;
        if (done_cnt != d0 + 3) begin
            bad++; $display("FAIL back_to_back_done: pulses %0d required 3", done_cnt - d0);
        end
    endtask

    initial begin
        bus_if.i_START     = 1'b0;
        bus_if.i_CENTER    = '0;
        bus_if.i_PIX       = '0;
        bus_if.i_PIX_VALID = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_start_ignored();
        test_mid_reset();
        test_tolerance();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
